// File: rtl/perf_event_counters.sv
// perf_event_counters: NUM_EVT event counters plus a cycle counter, sticky halt freeze and a registered read port.
// Define PERF_OVF_IRQ_EN to add sticky per-counter overflow flags and the registered ovf_irq output.
module perf_event_counters #(
    parameter int NUM_EVT = 4,
    parameter int CNT_W   = 32,
    parameter bit SAT     = 1'b0,
    parameter int SEL_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               halt,
    input  logic               clr,
    input  logic               rd_req,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic               rd_ack,
    output logic [CNT_W-1:0]   rd_data,
    output logic [CNT_W-1:0]   cycle_count,
`ifdef PERF_OVF_IRQ_EN
    output logic               frozen,
    output logic               ovf_irq
`else
    output logic               frozen
`endif
);
    localparam int NC = NUM_EVT + 1;

    typedef enum logic {IDLE, ACK} rd_state_e;

    rd_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q [NC];
    logic [CNT_W-1:0] cnt_d [NC];
    logic [NC-1:0]    inc, at_max;
    logic             frozen_q, frozen_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d, sel_val;

    // Slot NUM_EVT is the cycle counter: it ignores en but still stops when frozen.
    assign inc = {~frozen_q, {NUM_EVT{en & ~frozen_q}} & evt};

    always_comb begin
        for (int i = 0; i < NC; i++) begin
            at_max[i] = &cnt_q[i];
            cnt_d[i]  = clr ? '0 :
                        (inc[i] && !(SAT && at_max[i])) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
        end
        frozen_d = ~clr & (frozen_q | halt);
    end

    always_comb begin
        sel_val = '0;
        for (int i = 0; i < NC; i++)
            if (rd_sel == SEL_W'(i)) sel_val = cnt_q[i];
        state_d   = rd_req ? ACK : IDLE;
        rd_data_d = rd_req ? sel_val : rd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NC; i++) cnt_q[i] <= '0;
            frozen_q  <= 1'b0;
            state_q   <= IDLE;
            rd_data_q <= '0;
        end else begin
            for (int i = 0; i < NC; i++) cnt_q[i] <= cnt_d[i];
            frozen_q  <= frozen_d;
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_ack      = (state_q == ACK);
    assign rd_data     = rd_data_q;
    assign cycle_count = cnt_q[NUM_EVT];
    assign frozen      = frozen_q;

`ifdef PERF_OVF_IRQ_EN
    logic [NC-1:0] ovf_q, ovf_d, rd_hit;
    logic          ovf_irq_q, ovf_irq_d;

    // A fresh overflow wins over a same-cycle read clear so no event is lost.
    always_comb begin
        for (int i = 0; i < NC; i++) rd_hit[i] = rd_req && (rd_sel == SEL_W'(i));
        ovf_d     = clr ? '0 : (inc & at_max) | (ovf_q & ~rd_hit);
        ovf_irq_d = ~clr & (|ovf_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q     <= '0;
            ovf_irq_q <= 1'b0;
        end else begin
            ovf_q     <= ovf_d;
            ovf_irq_q <= ovf_irq_d;
        end
    end

    assign ovf_irq = ovf_irq_q;
`endif
endmodule

// File: doc/perf_event_counters.md
Name: perf_event_counters

Overview:
- Synthesizable, parametrised successor to the simulation-only instruction/cache-hit counting in the processor bench.
- Holds NUM_EVT independent event counters plus a free-running cycle counter.
- Freezes all counts when the processor halts, and serves a registered read port for debug/firmware readout.
- Sits beside proc top-level; event inputs are driven by pipeline and cache signals such as retire, icache req/hit and dcache req/hit.

Parameters:
- NUM_EVT, 4, number of event channels (1..16)
- CNT_W, 32, width of every counter, cycle counter included (8..64)
- SAT, 0, 1 = counters saturate at all-ones; 0 = counters wrap to 0
- SEL_W, 5, width of rd_sel; must satisfy 2^SEL_W > NUM_EVT

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- en  in  1  global count enable (gates event counters only, not the cycle counter)
- evt  in  NUM_EVT  per-channel increment strobes, one increment per cycle when high
- halt  in  1  processor halted; freezes all counters
- clr  in  1  synchronous clear of all counters and of the frozen state
- rd_req  in  1  read request strobe
- rd_sel  in  SEL_W  read index: 0..NUM_EVT-1 select event counters; NUM_EVT selects the cycle counter
- rd_ack  out  1  read data valid, single-cycle pulse
- rd_data  out  CNT_W  read result
- cycle_count  out  CNT_W  live cycle counter value
- frozen  out  1  counters frozen by halt
- ovf_irq  out  1  overflow interrupt; exists only with PERF_OVF_IRQ_EN

Behaviour:
- Reset (async, rst=1): all counters 0, frozen=0, rd_ack=0, rd_data=0, ovf state 0. Outputs hold these values while rst is high.
- Cycle counter: +1 every clk edge when rst=0, frozen=0 and clr=0.
- Event counter i: +1 when evt[i]=1, en=1, frozen=0 and clr=0. Several channels may increment in the same cycle independently.
- Overflow at all-ones:
  - SAT=1: counter holds at all-ones.
  - SAT=0: counter wraps to 0.
- Halt:
  - The halt cycle itself is still counted, in both event and cycle counters.
  - frozen=1 from the next edge and stays set (sticky) until clr or rst; dropping halt does not unfreeze.
- Clear:
  - clr=1 zeroes all counters and frozen at the next edge.
  - clr has priority over any same-cycle increment and over halt, so clr+halt gives frozen=0.
- Read port: two states, IDLE and ACK, one register stage.
  - rd_req=1 at edge N: rd_ack=1 and rd_data=selected counter value at edge N+1.
  - The value returned is the pre-increment value as sampled in cycle N.
  - Back-to-back rd_req on consecutive cycles is legal and yields consecutive acks.
  - rd_req=0: rd_ack=0 next cycle; rd_data holds its last value.
  - rd_sel > NUM_EVT: ack still asserts, rd_data=0.
  - rd_req together with clr returns the pre-clear value.
- No read stalls: reads never block counting.

Optional Feature:
- Macro: PERF_OVF_IRQ_EN
- Defined:
  - Per-channel sticky overflow flags (NUM_EVT+1, cycle counter included).
  - A flag sets on the cycle its counter goes from all-ones to 0 (SAT=0) or an increment is attempted at all-ones (SAT=1).
  - ovf_irq = OR of the flags, registered.
  - Reading an index with rd_req clears that index's flag on the same edge the data is captured.
  - clr and rst clear all flags.
- Undefined: no flags, no ovf_irq port, no extra logic.

Test Plan:
- Reset then 10 idle cycles, en=1, evt=0; read index NUM_EVT=4 -> rd_ack pulses one cycle later; rd_data = cycle count at the rd_req cycle (10 edges after rst drop, so 10); event reads return 0.
- evt=4'b0101 for 7 cycles with en=1, then en=0 for 3 cycles with evt high -> counters 0 and 2 read 7; counters 1 and 3 read 0.
- halt pulsed 1 cycle after 5 evt[1] strobes, evt[1] held high 20 more cycles -> frozen=1 at next edge; counter1=6 (halt cycle counted); cycle_count constant afterwards; clr then returns all counters to 0 and frozen to 0.
- CNT_W=8, SAT=0, 257 evt[0] strobes -> counter0=1. With SAT=1 the same stimulus gives 255. With PERF_OVF_IRQ_EN, ovf_irq=1 until index 0 is read, then 0 the cycle after.
- Back-to-back reads with rd_sel 0,1,4,9 on consecutive cycles -> four consecutive rd_ack cycles with matching values; sel 9 returns 0.
- rst asserted mid-read (rd_req high) -> rd_ack and rd_data 0 immediately, asynchronously; all counters 0 after release.
